// File: rtl/ccg_sig_collector.sv
// Exhaustive pattern driver plus MISR signature collector for a CCG combinational benchmark.
// Optional golden-signature comparator is enabled with `define CCG_SIG_GOLDEN_CMP_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; pat_out and sig hold last run's values
// DRIVE  | stepping pat_out through 0 .. 2^IN_W-1, one per cycle
// DRAIN  | pat_out held while the last RESP_LAT responses arrive
// DONE   | one-cycle done pulse, sig is final
module ccg_sig_collector #(
  parameter int                 IN_W     = 4,
  parameter int                 OUT_W    = 20,
  parameter logic [OUT_W-1:0]   POLY     = 20'h00009,
  parameter logic [OUT_W-1:0]   SEED     = '0,
  parameter int                 RESP_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  pat_out,
  input  logic [OUT_W-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] sig
`ifdef CCG_SIG_GOLDEN_CMP_EN
  ,
  input  logic [OUT_W-1:0] golden,
  output logic             pass
`endif
);

  localparam int             CW         = IN_W + 1;
  localparam int             DW         = (RESP_LAT > 0) ? RESP_LAT : 1;
  localparam logic [CW-1:0]  NPAT       = CW'(1) << IN_W;
  localparam logic [CW-1:0]  LAST_DRAIN = CW'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic [DW-1:0]    qual_dly;
  logic             drive_now;
  logic             absorb;
  logic             done_set;
  logic [OUT_W-1:0] misr_next;
  logic [OUT_W-1:0] sig_upd;

  always_comb begin
    drive_now = (state == S_DRIVE);
    cnt_inc   = cnt + CW'(1);
    // With zero latency the response to the current pattern is already present.
    absorb    = (RESP_LAT == 0) ? drive_now : qual_dly[DW-1];
    misr_next = {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? POLY : '0) ^ resp_in;
    sig_upd   = absorb ? misr_next : sig;
    done_set  = ((state == S_DRIVE) && (cnt_inc == NPAT) && (RESP_LAT == 0)) ||
                ((state == S_DRAIN) && (cnt == LAST_DRAIN));
  end

  generate
    if (DW == 1) begin : g_dly_1
      always_ff @(posedge clk) begin
        if (rst) qual_dly <= '0;
        else     qual_dly <= drive_now;
      end
    end else begin : g_dly_n
      always_ff @(posedge clk) begin
        if (rst) qual_dly <= '0;
        else     qual_dly <= {qual_dly[DW-2:0], drive_now};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pat_out <= '0;
      sig     <= SEED;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= done_set;
      sig  <= sig_upd;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_DRIVE;
            cnt     <= '0;
            pat_out <= '0;
            sig     <= SEED;
            busy    <= 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt_inc == NPAT) begin
            cnt   <= '0;
            state <= (RESP_LAT == 0) ? S_DONE : S_DRAIN;
          end else begin
            cnt     <= cnt_inc;
            pat_out <= cnt_inc[IN_W-1:0];
          end
        end
        S_DRAIN: begin
          if (cnt == LAST_DRAIN) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CCG_SIG_GOLDEN_CMP_EN
  // Compare against the value sig takes on the same edge that done rises.
  always_ff @(posedge clk) begin
    if (rst)                             pass <= 1'b0;
    else if ((state == S_IDLE) && start) pass <= 1'b0;
    else if (done_set)                   pass <= (sig_upd == golden);
  end
`endif

endmodule

// File: tb/tb_ccg_sig_collector.sv
// Directed bench for ccg_sig_collector: timing, signatures, abort, and benchmark loopback.
module tb_ccg_sig_collector;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [1:0]  mode;
  logic [3:0]  pat_def, pat_seed, pat_lat;
  logic [19:0] resp_def, resp_seed, resp_lat;
  logic [19:0] sig_def, sig_seed, sig_lat;
  logic        busy_def, busy_seed, busy_lat;
  logic        done_def, done_seed, done_lat;
`ifdef CCG_SIG_GOLDEN_CMP_EN
  logic [19:0] golden_def, golden_zero;
  logic        pass_def, pass_seed, pass_lat;
`endif

  int total = 0;
  int bad   = 0;

  function automatic logic [19:0] f_a(input logic [3:0] x);
    return {x ^ 4'h5, x & {x[0], x[3:1]}, x | 4'b1010, ~x, {x[2:0], x[3]} ^ x};
  endfunction

  // Restructured but equivalent form of f_a.
  function automatic logic [19:0] f_b(input logic [3:0] x);
    return {x[3], ~x[2], x[1], ~x[0],
            x[3] & x[0], x[2] & x[3], x[1] & x[2], x[0] & x[1],
            1'b1, x[2], 1'b1, x[0],
            4'hF ^ x,
            x[2] ^ x[3], x[1] ^ x[2], x[0] ^ x[1], x[3] ^ x[0]};
  endfunction

  function automatic logic [19:0] misr_ref();
    logic [19:0] s;
    s = '0;
    for (int k = 0; k < 16; k++)
      s = {s[18:0], 1'b0} ^ (s[19] ? 20'h00009 : 20'h0) ^ f_a(4'(k));
    return s;
  endfunction

  always_comb begin
    resp_def = 20'h00001;
    case (mode)
      2'd1:    resp_def = f_a(pat_def);
      2'd2:    resp_def = f_b(pat_def);
      2'd3:    resp_def = f_b(pat_def) | 20'h00001;
      default: resp_def = 20'h00001;
    endcase
  end
  assign resp_seed = 20'h00000;
  assign resp_lat  = 20'h00001;

  ccg_sig_collector u_def (
    .clk(clk), .rst(rst), .start(start), .pat_out(pat_def), .resp_in(resp_def),
    .busy(busy_def), .done(done_def), .sig(sig_def)
`ifdef CCG_SIG_GOLDEN_CMP_EN
    , .golden(golden_def), .pass(pass_def)
`endif
  );

  ccg_sig_collector #(.SEED(20'h80000)) u_seed (
    .clk(clk), .rst(rst), .start(start), .pat_out(pat_seed), .resp_in(resp_seed),
    .busy(busy_seed), .done(done_seed), .sig(sig_seed)
`ifdef CCG_SIG_GOLDEN_CMP_EN
    , .golden(golden_zero), .pass(pass_seed)
`endif
  );

  ccg_sig_collector #(.RESP_LAT(2)) u_lat (
    .clk(clk), .rst(rst), .start(start), .pat_out(pat_lat), .resp_in(resp_lat),
    .busy(busy_lat), .done(done_lat), .sig(sig_lat)
`ifdef CCG_SIG_GOLDEN_CMP_EN
    , .golden(golden_zero), .pass(pass_lat)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done_def(input int budget);
    for (int i = 0; i < budget && !done_def; i++) @(negedge clk);
    chk("def_done_seen", done_def, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] ref_sig;
    int exp_pat;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'd0;
`ifdef CCG_SIG_GOLDEN_CMP_EN
    golden_def  = 20'h0FFFF;
    golden_zero = 20'h0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_def, 0);
    chk("rst_done", done_def, 0);
    chk("rst_pat", pat_def, 0);
    chk("rst_sig_def", sig_def, 20'h00000);
    chk("rst_sig_seed", sig_seed, 20'h80000);
`ifdef CCG_SIG_GOLDEN_CMP_EN
    chk("rst_pass", pass_def, 0);
`endif
    rst = 1'b0;

    // Run 1: all three instances in parallel; n counts edges after the start edge.
    pulse_start();
    for (int n = 0; n <= 20; n++) begin
      if (n <= 15) chk($sformatf("def_pat@%0d", n), pat_def, n);
      chk($sformatf("def_done@%0d", n), done_def, (n == 16));
      chk($sformatf("def_busy@%0d", n), busy_def, (n <= 16));
      chk($sformatf("seed_done@%0d", n), done_seed, (n == 16));
      exp_pat = (n > 15) ? 15 : n;
      if (n <= 18) chk($sformatf("lat_pat@%0d", n), pat_lat, exp_pat);
      chk($sformatf("lat_done@%0d", n), done_lat, (n == 18));
      chk($sformatf("lat_busy@%0d", n), busy_lat, (n <= 18));
      if (n == 16) begin
        chk("def_sig_at_done", sig_def, 20'h0FFFF);
        chk("seed_sig_at_done", sig_seed, 20'h48000);
`ifdef CCG_SIG_GOLDEN_CMP_EN
        chk("pass_match", pass_def, 1);
`endif
        start = 1'b1;
      end
      if (n == 17) start = 1'b0;
      if (n == 18) chk("lat_sig_at_done", sig_lat, 20'h0FFFF);
      @(negedge clk);
    end
    chk("def_sig_held", sig_def, 20'h0FFFF);
    chk("seed_sig_held", sig_seed, 20'h48000);
    chk("lat_sig_held", sig_lat, 20'h0FFFF);
`ifdef CCG_SIG_GOLDEN_CMP_EN
    chk("pass_held", pass_def, 1);
    golden_def = 20'h0FFFE;
`endif

    // Run 2: same stimulus, mismatching golden.
    pulse_start();
`ifdef CCG_SIG_GOLDEN_CMP_EN
    chk("pass_cleared", pass_def, 0);
`endif
    wait_done_def(40);
    chk("def_sig_run2", sig_def, 20'h0FFFF);
`ifdef CCG_SIG_GOLDEN_CMP_EN
    chk("pass_mismatch", pass_def, 0);
`endif
    repeat (4) @(negedge clk);

    // Abort: start held high through the run, reset at pattern 7.
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("abort_pat3", pat_def, 3);
    repeat (4) @(negedge clk);
    chk("abort_pat7", pat_def, 7);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy_def, 0);
    chk("abort_done", done_def, 0);
    chk("abort_pat", pat_def, 0);
    chk("abort_sig_def", sig_def, 20'h00000);
    chk("abort_sig_seed", sig_seed, 20'h80000);
    rst   = 1'b0;
    start = 1'b0;
    pulse_start();
    wait_done_def(40);
    chk("after_abort_sig", sig_def, 20'h0FFFF);
    repeat (4) @(negedge clk);

    // Benchmark loopback: variant A, equivalent variant B, B with a stuck output.
    ref_sig = misr_ref();
    mode = 2'd1;
    pulse_start();
    wait_done_def(40);
    chk("loop_a_sig", sig_def, ref_sig);
    repeat (2) @(negedge clk);
    mode = 2'd2;
    pulse_start();
    wait_done_def(40);
    chk("loop_b_sig", sig_def, ref_sig);
    repeat (2) @(negedge clk);
    mode = 2'd3;
    pulse_start();
    wait_done_def(40);
    chk("loop_stuck_differs", (sig_def != ref_sig), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
